vga_timing_gen: RTL and testbench

- Produces 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives DrawX/DrawY, blank, hs and vs.
- Consumers are the per-pixel sprite/background renderers. Those renderers read ROM on the negedge and register colour on the next posedge, so their colour lags DrawX/DrawY by SYNC_DELAY cycles.
- This block delays blank/hs/vs by the same amount so that sync, blanking and pixel colour leave the chip aligned.

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with SYNC_DELAY-aligned blank/hs/vs
// Optional colour-bar test pattern outputs under VGA_TESTPAT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
`ifdef VGA_TESTPAT_EN
  ,
  output logic [3:0]  tp_red,
  output logic [3:0]  tp_green,
  output logic [3:0]  tp_blue
`endif
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

`ifdef VGA_TESTPAT_EN
  localparam int PW = 15;
`else
  localparam int PW = 3;
`endif
  // Stage word layout: {colour (optional), vs, hs, blank}; idle = blanked, syncs high.
  localparam logic [PW-1:0] IDLE_W = {{(PW-3){1'b0}}, 3'b110};

  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          h_wrap, v_wrap;
  logic          blank_raw, hs_raw, vs_raw;
  logic [PW-1:0] raw_w, out_w;

  assign h_wrap        = (hc_q == H_LAST);
  assign v_wrap        = (vc_q == V_LAST);
  assign hc_d          = h_wrap ? 10'd0 : hc_q + 10'd1;
  assign vc_d          = h_wrap ? (v_wrap ? 10'd0 : vc_q + 10'd1) : vc_q;
  assign frame_count_d = (h_wrap && v_wrap) ? frame_count_q + 16'd1 : frame_count_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      frame_count_q <= 16'd0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign blank_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_raw    = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vs_raw    = !((vc_q >= VS_START) && (vc_q < VS_END));

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar;
  assign bar   = 3'(hc_q / 10'd80);
  assign raw_w = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}, vs_raw, hs_raw, blank_raw};
`else
  assign raw_w = {vs_raw, hs_raw, blank_raw};
`endif

  // Matches the renderers' colour latency so sync and pixels leave the chip together.
  generate
    if (SYNC_DELAY == 0) begin : g_nodelay
      assign out_w = raw_w;
    end else begin : g_delay
      logic [PW-1:0] pipe_q [SYNC_DELAY];
      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) pipe_q[i] <= IDLE_W;
        end else begin
          pipe_q[0] <= raw_w;
          for (int i = 1; i < SYNC_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign out_w = pipe_q[SYNC_DELAY-1];
    end
  endgenerate

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = out_w[0];
  assign hs          = out_w[1];
  assign vs          = out_w[2];
  assign line_start  = (hc_q == 10'd0);
  assign frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
  assign frame_count = frame_count_q;

`ifdef VGA_TESTPAT_EN
  assign tp_blue  = out_w[6:3]   & {4{out_w[0]}};
  assign tp_green = out_w[10:7]  & {4{out_w[0]}};
  assign tp_red   = out_w[14:11] & {4{out_w[0]}};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen with a queue-based scoreboard
// Colour checks compile in only when VGA_TESTPAT_EN is defined.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  always #20 clk = ~clk;

  logic [9:0]  def_x, def_y, d0_x, d0_y, d3_x, d3_y, sm_x, sm_y;
  logic        def_blank, def_hs, def_vs, def_ls, def_fs;
  logic        d0_blank, d0_hs, d0_vs, d0_ls, d0_fs;
  logic        d3_blank, d3_hs, d3_vs, d3_ls, d3_fs;
  logic        sm_blank, sm_hs, sm_vs, sm_ls, sm_fs;
  logic [15:0] def_fc, d0_fc, d3_fc, sm_fc;
`ifdef VGA_TESTPAT_EN
  logic [3:0]  tp_r [4];
  logic [3:0]  tp_g [4];
  logic [3:0]  tp_b [4];
`endif

  vga_timing_gen #(.SYNC_DELAY(1)) u_def (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(def_x), .DrawY(def_y), .blank(def_blank),
    .hs(def_hs), .vs(def_vs), .line_start(def_ls), .frame_start(def_fs), .frame_count(def_fc)
`ifdef VGA_TESTPAT_EN
    , .tp_red(tp_r[0]), .tp_green(tp_g[0]), .tp_blue(tp_b[0])
`endif
  );

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank),
    .hs(d0_hs), .vs(d0_vs), .line_start(d0_ls), .frame_start(d0_fs), .frame_count(d0_fc)
`ifdef VGA_TESTPAT_EN
    , .tp_red(tp_r[1]), .tp_green(tp_g[1]), .tp_blue(tp_b[1])
`endif
  );

  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d3_x), .DrawY(d3_y), .blank(d3_blank),
    .hs(d3_hs), .vs(d3_vs), .line_start(d3_ls), .frame_start(d3_fs), .frame_count(d3_fc)
`ifdef VGA_TESTPAT_EN
    , .tp_red(tp_r[2]), .tp_green(tp_g[2]), .tp_blue(tp_b[2])
`endif
  );

  // Shrunken raster: 30 x 15 = 450 cycles/frame, hs low at hc 20..25, vs low at vc 10..11.
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(1)
  ) u_sm (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(sm_x), .DrawY(sm_y), .blank(sm_blank),
    .hs(sm_hs), .vs(sm_vs), .line_start(sm_ls), .frame_start(sm_fs), .frame_count(sm_fc)
`ifdef VGA_TESTPAT_EN
    , .tp_red(tp_r[3]), .tp_green(tp_g[3]), .tp_blue(tp_b[3])
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sm_raw(input int h, input int v);
    logic b, hn, vn;
    b  = (h < 16) && (v < 8);
    hn = !((h >= 20) && (h < 26));
    vn = !((v >= 10) && (v < 12));
    return {vn, hn, b};
  endfunction

  // Scoreboard for u_sm: each posedge pushes the raw {vs,hs,blank} the model predicts,
  // each negedge pops the entry due after one stage of delay.
  int          m_hc, m_vc;
  logic [15:0] m_fc;
  logic [2:0]  exp_q [$];
  logic [2:0]  e;
  logic        chk_en = 1'b0;
  int          sm_err = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_hc = 0; m_vc = 0; m_fc = 16'd0;
      exp_q.delete();
      exp_q.push_back(3'b110);
    end else if (m_hc == 29) begin
      m_hc = 0;
      if (m_vc == 14) begin m_vc = 0; m_fc = m_fc + 16'd1; end
      else m_vc = m_vc + 1;
    end else begin
      m_hc = m_hc + 1;
    end
    exp_q.push_back(sm_raw(m_hc, m_vc));
  end

  always @(negedge clk) begin
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      if (chk_en && ({sm_vs, sm_hs, sm_blank} !== e || sm_x !== 10'(m_hc) || sm_y !== 10'(m_vc) ||
                     sm_fc !== m_fc || sm_ls !== (m_hc == 0) || sm_fs !== (m_hc == 0 && m_vc == 0)))
        sm_err++;
    end
  end

  int n;
  int ls_period, hs_fall_x, hs_low, d0_fall_x, d3_fall_x, blank_rise_x, blank_fall_x;
  int sm_fs_cnt, sm_fc3, sm_vs_low, sm_vblank_vis;
  logic p_hs, p_d0hs, p_d3hs, p_blank;
`ifdef VGA_TESTPAT_EN
  logic [11:0] tp_at1, tp_at401, tp_at701;
`endif

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold_x", def_x, 0);
    repeat (2) @(negedge clk);
    chk("rst_x", def_x, 0);
    chk("rst_y", def_y, 0);
    chk("rst_blank", def_blank, 0);
    chk("rst_hs", def_hs, 1);
    chk("rst_vs", def_vs, 1);
    chk("rst_fc", def_fc, 0);
    chk("rst_d3_hs", d3_hs, 1);
    chk("rst_sm_fc", sm_fc, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    chk("rel_ls", def_ls, 1);
    chk("rel_fs", def_fs, 1);

    n = 0;
    while (!(sm_x == 10'd10 && sm_y == 10'd5) && n < 600) begin @(negedge clk); n++; end
    chk("seek_mid_frame", n < 600, 1);
    chk("pre_reset_blank", sm_blank, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_x", sm_x, 0);
    chk("mid_y", sm_y, 0);
    chk("mid_blank", sm_blank, 0);
    chk("mid_hs", sm_hs, 1);
    chk("mid_vs", sm_vs, 1);
    chk("mid_fc", sm_fc, 0);
    chk("mid_ls", sm_ls, 1);
    chk("mid_fs", sm_fs, 1);

    ls_period = -1; hs_fall_x = -1; hs_low = 0; d0_fall_x = -1; d3_fall_x = -1;
    blank_rise_x = -1; blank_fall_x = -1;
    sm_fs_cnt = 0; sm_fc3 = -1; sm_vs_low = 0; sm_vblank_vis = 0;
    for (int i = 0; i < 1800; i++) begin
      if (i > 0) begin
        if (def_ls && ls_period < 0) ls_period = i;
        if (p_hs && !def_hs && hs_fall_x < 0) hs_fall_x = int'(def_x);
        if (p_d0hs && !d0_hs && d0_fall_x < 0) d0_fall_x = int'(d0_x);
        if (p_d3hs && !d3_hs && d3_fall_x < 0) d3_fall_x = int'(d3_x);
        if (!p_blank && def_blank && blank_rise_x < 0) blank_rise_x = int'(def_x);
        if (p_blank && !def_blank && blank_fall_x < 0) blank_fall_x = int'(def_x);
        if (sm_fs && i <= 1360) sm_fs_cnt++;
      end
      if (i < 800 && !def_hs) hs_low++;
      if (i < 450 && !sm_vs) sm_vs_low++;
      if (sm_y >= 10'd8 && sm_blank) sm_vblank_vis++;
      if (i == 1360) sm_fc3 = int'(sm_fc);
`ifdef VGA_TESTPAT_EN
      if (i == 1)   tp_at1   = {tp_r[0], tp_g[0], tp_b[0]};
      if (i == 401) tp_at401 = {tp_r[0], tp_g[0], tp_b[0]};
      if (i == 701) tp_at701 = {tp_r[0], tp_g[0], tp_b[0]};
`endif
      p_hs = def_hs; p_d0hs = d0_hs; p_d3hs = d3_hs; p_blank = def_blank;
      @(negedge clk);
    end
    chk("line_period", ls_period, 800);
    chk("hs_fall_x_d1", hs_fall_x, 657);
    chk("hs_low_len", hs_low, 96);
    chk("hs_fall_x_d0", d0_fall_x, 656);
    chk("hs_fall_x_d3", d3_fall_x, 659);
    chk("blank_rise_x", blank_rise_x, 1);
    chk("blank_fall_x", blank_fall_x, 641);
    chk("sm_frame_pulses", sm_fs_cnt, 3);
    chk("sm_fc_3", sm_fc3, 3);
    chk("sm_vs_low_len", sm_vs_low, 60);
    chk("sm_vblank_vis", sm_vblank_vis, 0);
`ifdef VGA_TESTPAT_EN
    chk("tp_x0", tp_at1, 12'h000);
    chk("tp_x400", tp_at401, 12'hF0F);
    chk("tp_x700", tp_at701, 12'h000);
`endif

    chk_en = 1'b0;
    force u_sm.frame_count_d = 16'hFFFF;
    @(negedge clk);
    release u_sm.frame_count_d;
    m_fc = 16'hFFFF;
    chk("force_fc", sm_fc, 16'hFFFF);
    @(negedge clk);
    chk_en = 1'b1;
    n = 0;
    while (!sm_fs && n < 500) begin @(negedge clk); n++; end
    chk("seek_wrap", n < 500, 1);
    chk("wrap_fc", sm_fc, 16'h0000);
    chk("scoreboard_err", sm_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
